fft_addr_ctrl: RTL

FFT_ADDR_CTRL -- requirements
Module: fft_addr_ctrl

---
 rtl/fft_addr_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_addr_ctrl
// Brief    : Address/sequence controller for an in-place radix-2 FFT RAM
//            (load, per-butterfly read/wait/write, natural-order unload).
//            Define FFT_CTRL_BITREV_EN to bit-reverse load addresses.
// Revision : 1.0 - initial release
// ============================================================================
module fft_addr_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int BFLY_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  ram_row,
    output logic                  ram_singlewrite,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    output logic [ADDR_WIDTH-2:0] tw_addr,
    output logic                  bfly_en,
    output logic                  busy,
    output logic                  done
);

    localparam int c_SW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;

    localparam logic [c_SW-1:0]       c_LAST_STAGE = c_SW'(ADDR_WIDTH - 1);
    localparam logic [c_SW-1:0]       c_ONE_S      = c_SW'(1);
    localparam logic [ADDR_WIDTH-2:0] c_LAST_BFLY  = '1;
    localparam logic [ADDR_WIDTH-2:0] c_ONE_J      = (ADDR_WIDTH-1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX   = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ONE_A      = ADDR_WIDTH'(1);
    localparam logic [2:0]            c_WAIT_LAST  = 3'(BFLY_LAT - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_READ   = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;
    localparam logic [2:0] c_ST_UNLOAD = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [c_SW-1:0]       r_s;
    logic [ADDR_WIDTH-2:0] r_j;
    logic [2:0]            r_wait;
    logic [ADDR_WIDTH-1:0] r_out_idx;
    logic                  r_out_valid;
    logic                  r_bfly_en;

    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic [ADDR_WIDTH-1:0] w_j_ext;
    logic [ADDR_WIDTH-1:0] w_span;
    logic [ADDR_WIDTH-1:0] w_pos;
    logic [ADDR_WIDTH-1:0] w_grp;
    logic [ADDR_WIDTH-1:0] w_bf_a;
    logic [ADDR_WIDTH-1:0] w_bf_b;
    logic [ADDR_WIDTH-1:0] w_tw_full;
    logic                  w_last_bfly;
    logic                  w_accept;

`ifdef FFT_CTRL_BITREV_EN
    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_bitrev
            assign w_load_addr[gi] = r_k[ADDR_WIDTH-1-gi];
        end
    endgenerate
`else
    assign w_load_addr = r_k;
`endif

    // Butterfly j of stage s pairs a = grp*2*span + pos with b = a + span.
    assign w_j_ext   = {1'b0, r_j};
    assign w_span    = c_ONE_A << r_s;
    assign w_pos     = w_j_ext & (w_span - c_ONE_A);
    assign w_grp     = w_j_ext >> r_s;
    assign w_bf_a    = (w_grp << (r_s + c_ONE_S)) | w_pos;
    assign w_bf_b    = w_bf_a + w_span;
    assign w_tw_full = w_pos << (c_LAST_STAGE - r_s);

    assign w_last_bfly = (r_s == c_LAST_STAGE) && (r_j == c_LAST_BFLY);
    assign w_accept    = (r_state == c_ST_UNLOAD) && r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_k         <= '0;
            r_s         <= '0;
            r_j         <= '0;
            r_wait      <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_bfly_en   <= 1'b0;
        end else begin
            r_bfly_en <= (r_state == c_ST_READ);
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_LOAD;
                        r_k     <= '0;
                    end
                end
                c_ST_LOAD: begin
                    if (in_valid) begin
                        r_k <= r_k + c_ONE_A;
                        if (r_k == c_LAST_IDX) begin
                            r_state <= c_ST_READ;
                            r_s     <= '0;
                            r_j     <= '0;
                        end
                    end
                end
                c_ST_READ: begin
                    r_state <= c_ST_WAIT;
                    r_wait  <= '0;
                end
                c_ST_WAIT: begin
                    if (r_wait == c_WAIT_LAST) begin
                        r_state <= c_ST_WRITE;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                c_ST_WRITE: begin
                    if (w_last_bfly) begin
                        r_state     <= c_ST_UNLOAD;
                        r_out_idx   <= '0;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= c_ST_READ;
                        r_j     <= r_j + c_ONE_J;
                        if (r_j == c_LAST_BFLY) begin
                            r_s <= r_s + c_ONE_S;
                        end
                    end
                end
                c_ST_UNLOAD: begin
                    // A gap cycle after each accept lets the RAM read settle on the new index.
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (r_out_idx == c_LAST_IDX) begin
                            r_state   <= c_ST_IDLE;
                            r_out_idx <= '0;
                        end else begin
                            r_out_idx <= r_out_idx + c_ONE_A;
                        end
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready        = 1'b0;
        ram_singlewrite = 1'b0;
        ram_row         = 1'b0;
        ram_a_addr      = '0;
        ram_b_addr      = '0;
        tw_addr         = '0;
        case (r_state)
            c_ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ram_singlewrite = 1'b1;
                    ram_a_addr      = w_load_addr;
                end
            end
            c_ST_READ, c_ST_WAIT: begin
                ram_a_addr = w_bf_a;
                ram_b_addr = w_bf_b;
                tw_addr    = w_tw_full[ADDR_WIDTH-2:0];
            end
            c_ST_WRITE: begin
                ram_row    = 1'b1;
                ram_a_addr = w_bf_a;
                ram_b_addr = w_bf_b;
                tw_addr    = w_tw_full[ADDR_WIDTH-2:0];
            end
            c_ST_UNLOAD: begin
                ram_a_addr = r_out_idx;
                ram_b_addr = r_out_idx;
            end
            default: begin
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign bfly_en   = r_bfly_en;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = w_accept && (r_out_idx == c_LAST_IDX);

endmodule
`default_nettype wire
